// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: run control from the CPU, program-memory address/data,
// and the opcode/enable hand-off to the control unit.
interface fetch_unit_if #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 16
);
  logic                   start;
  logic                   stall;
  logic                   s_inc;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    pc;
  logic [5:0]             opcode;
  logic                   exec_en;
  logic                   running;
  logic                   halted;
  logic                   stack_err;

  modport master (
    input  start, stall, s_inc, instr,
    output pc, opcode, exec_en, running, halted, stack_err
  );

  modport slave (
    output start, stall, s_inc, instr,
    input  pc, opcode, exec_en, running, halted, stack_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch/sequencing: PC, IDLE/RUN/HALTED control and next-PC select.
// Define FETCH_STACK_EN to add the CALL/RET hardware return stack.
module fetch_unit #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam logic [5:0]          OP_HALT = 6'b001111;
  localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target;
  logic                exec_en;

  assign bus.opcode  = bus.instr[INSTR_WIDTH-1 -: 6];
  assign target      = bus.instr[PC_WIDTH-1:0];
  assign pc_inc      = pc_q + PC_ONE;
  assign bus.pc      = pc_q;
  assign bus.exec_en = exec_en;
  assign bus.running = (state_q == S_RUN);
  assign bus.halted  = (state_q == S_HALTED);

`ifdef FETCH_STACK_EN
  localparam logic [5:0] OP_CALL = 6'b001100;
  localparam logic [5:0] OP_RET  = 6'b001101;
  localparam int         SPW     = $clog2(STACK_DEPTH);
  localparam logic [SPW:0] SP_FULL = STACK_DEPTH[SPW:0];
  localparam logic [SPW:0] SP_ONE  = 1;

  // One spare pointer bit distinguishes full from empty.
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SPW:0]        sp_q, sp_d, sp_dec;
  logic                push;
  logic                stack_err_q, stack_err_d;

  assign sp_dec        = sp_q - SP_ONE;
  assign bus.stack_err = stack_err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[sp_q[SPW-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q        <= '0;
      stack_err_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
    end
  end
`else
  assign bus.stack_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    exec_en = 1'b0;
`ifdef FETCH_STACK_EN
    sp_d        = sp_q;
    push        = 1'b0;
    stack_err_d = stack_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (bus.opcode == OP_HALT) begin
            state_d = S_HALTED;
`ifdef FETCH_STACK_EN
          end else if (bus.opcode == OP_CALL) begin
            if (sp_q == SP_FULL) begin
              stack_err_d = 1'b1;
              state_d     = S_HALTED;
            end else begin
              exec_en = 1'b1;
              push    = 1'b1;
              sp_d    = sp_q + SP_ONE;
              pc_d    = target;
            end
          end else if (bus.opcode == OP_RET) begin
            if (sp_q == '0) begin
              stack_err_d = 1'b1;
              state_d     = S_HALTED;
            end else begin
              exec_en = 1'b1;
              sp_d    = sp_dec;
              pc_d    = stack_mem[sp_dec[SPW-1:0]];
            end
`endif
          end else begin
            exec_en = 1'b1;
            pc_d    = bus.s_inc ? pc_inc : target;
          end
        end
      end
      S_HALTED: begin
        if (!bus.start) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int PW = 10;
  localparam int IW = 16;
  localparam int DEPTH = 4;
  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_HALT = 6'b001111;
  localparam logic [5:0] OP_CALL = 6'b001100;
  localparam logic [5:0] OP_RET  = 6'b001101;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic reset;
  logic [IW-1:0] mem [1024];
  int n_vec = 0;
  int n_err = 0;

  int m_mode = M_IDLE;
  int m_pc = 0;
  int m_err = 0;
  int m_stk[$];
  logic [5:0] m_opv;

  fetch_unit_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) bus ();
  assign bus.instr = mem[bus.pc];

  fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .STACK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_exec();
    logic [5:0] op;
    op = mem[m_pc][15:10];
    if (m_mode != M_RUN || bus.stall || op == OP_HALT) return 1'b0;
`ifdef FETCH_STACK_EN
    if (op == OP_CALL && m_stk.size() == DEPTH) return 1'b0;
    if (op == OP_RET && m_stk.size() == 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Model: one instruction per unstalled RUN cycle, next PC from plain arithmetic.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE;
      m_pc   = 0;
      m_err  = 0;
      m_stk.delete();
    end else begin
      m_opv = mem[m_pc][15:10];
      if (m_mode == M_IDLE) begin
        if (bus.start) m_mode = M_RUN;
      end else if (m_mode == M_HALT) begin
        if (!bus.start) begin
          m_mode = M_IDLE;
          m_pc   = 0;
        end
      end else if (!bus.stall) begin
        if (m_opv == OP_HALT) begin
          m_mode = M_HALT;
`ifdef FETCH_STACK_EN
        end else if (m_opv == OP_CALL) begin
          if (m_stk.size() == DEPTH) begin
            m_err = 1; m_mode = M_HALT;
          end else begin
            m_stk.push_back((m_pc + 1) % 1024);
            m_pc = int'(mem[m_pc][9:0]);
          end
        end else if (m_opv == OP_RET) begin
          if (m_stk.size() == 0) begin
            m_err = 1; m_mode = M_HALT;
          end else begin
            m_pc = m_stk.pop_back();
          end
`endif
        end else begin
          m_pc = bus.s_inc ? (m_pc + 1) % 1024 : int'(mem[m_pc][9:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("pc",        {22'd0, bus.pc},     m_pc);
      chk("exec_en",   {31'd0, bus.exec_en}, {31'd0, m_exec()});
      chk("running",   {31'd0, bus.running}, {31'd0, m_mode == M_RUN});
      chk("halted",    {31'd0, bus.halted},  {31'd0, m_mode == M_HALT});
      chk("stack_err", {31'd0, bus.stack_err}, m_err);
      chk("opcode",    {26'd0, bus.opcode},  {26'd0, mem[m_pc][15:10]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Called at posedge+2: low from +3, checked at +4, released at +6..+8.
  task automatic async_reset(input int hold);
    #1 reset = 1'b0;
    #1;
    chk("rst_pc",        {22'd0, bus.pc}, 0);
    chk("rst_running",   {31'd0, bus.running}, 0);
    chk("rst_exec_en",   {31'd0, bus.exec_en}, 0);
    chk("rst_stack_err", {31'd0, bus.stack_err}, 0);
    #(hold) reset = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.s_inc = 1'b1;
    reset = 1'b1;
    for (int a = 0; a < 1024; a++) mem[a] = {OP_ADD, 10'($urandom)};
    mem[2] = {OP_HALT, 10'd0};
    mem[5] = {OP_ADD, 10'h3F0};
    #1 reset = 1'b0;
    #11 reset = 1'b1;

    cyc();
    chk("idle_pc", {22'd0, bus.pc}, 0);
    chk("idle_running", {31'd0, bus.running}, 0);
    chk("idle_halted", {31'd0, bus.halted}, 0);
    bus.start = 1'b1;
    cyc();
    chk("run0_pc", {22'd0, bus.pc}, 0);
    chk("run0_exec", {31'd0, bus.exec_en}, 1);
    cyc();
    chk("run1_pc", {22'd0, bus.pc}, 1);
    cyc();
    chk("halt_pc", {22'd0, bus.pc}, 2);
    chk("halt_exec", {31'd0, bus.exec_en}, 0);
    cyc();
    chk("halted", {31'd0, bus.halted}, 1);
    chk("halted_pc", {22'd0, bus.pc}, 2);
    mem[2] = {OP_ADD, 10'd0};
    bus.start = 1'b0;
    cyc();
    chk("back_idle_pc", {22'd0, bus.pc}, 0);
    chk("back_idle_halted", {31'd0, bus.halted}, 0);
    bus.start = 1'b1;
    cyc();
    chk("restart_running", {31'd0, bus.running}, 1);
    chk("restart_pc", {22'd0, bus.pc}, 0);

    repeat (5) cyc();
    chk("at5_pc", {22'd0, bus.pc}, 5);
    bus.s_inc = 1'b0;
    cyc();
    chk("jump_pc", {22'd0, bus.pc}, 32'h3F0);
    bus.s_inc = 1'b1;
    repeat (15) cyc();
    chk("top_pc", {22'd0, bus.pc}, 32'h3FF);
    cyc();
    chk("wrap_pc", {22'd0, bus.pc}, 0);

    repeat (7) cyc();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_pc", {22'd0, bus.pc}, 7);
      chk("stall_exec", {31'd0, bus.exec_en}, 0);
      cyc();
    end
    bus.stall = 1'b0;
    cyc();
    chk("unstall_pc", {22'd0, bus.pc}, 8);
    mem[8] = {OP_ADD, 10'h123};
    bus.s_inc = 1'b0;
    cyc();
    chk("at123_pc", {22'd0, bus.pc}, 32'h123);
    bus.s_inc = 1'b1;
    bus.start = 1'b0;
    async_reset(2);

`ifdef FETCH_STACK_EN
    mem[0]     = {OP_ADD,  10'h010};
    mem[10'h010] = {OP_CALL, 10'h100};
    mem[10'h100] = {OP_RET,  10'h000};
    mem[10'h011] = {OP_CALL, 10'h020};
    mem[10'h020] = {OP_CALL, 10'h030};
    mem[10'h030] = {OP_CALL, 10'h040};
    mem[10'h040] = {OP_CALL, 10'h050};
    mem[10'h050] = {OP_CALL, 10'h060};
    bus.start = 1'b1;
    cyc();
    bus.s_inc = 1'b0;
    cyc();
    chk("call_src_pc", {22'd0, bus.pc}, 32'h010);
    bus.s_inc = 1'b1;
    cyc();
    chk("call_pc", {22'd0, bus.pc}, 32'h100);
    cyc();
    chk("ret_pc", {22'd0, bus.pc}, 32'h011);
    repeat (4) cyc();
    chk("nest_pc", {22'd0, bus.pc}, 32'h050);
    chk("nest_exec", {31'd0, bus.exec_en}, 0);
    cyc();
    chk("ovf_err", {31'd0, bus.stack_err}, 1);
    chk("ovf_halted", {31'd0, bus.halted}, 1);
    chk("ovf_pc", {22'd0, bus.pc}, 32'h050);
    bus.start = 1'b0;
    async_reset(2);
    mem[0] = {OP_RET, 10'h0AA};
    bus.start = 1'b1;
    cyc();
    chk("unf_exec", {31'd0, bus.exec_en}, 0);
    cyc();
    chk("unf_err", {31'd0, bus.stack_err}, 1);
    chk("unf_halted", {31'd0, bus.halted}, 1);
    chk("unf_pc", {22'd0, bus.pc}, 0);
    bus.start = 1'b0;
    async_reset(2);
`endif

    for (int a = 0; a < 1024; a++) begin
      int r;
      logic [5:0] op;
      r = int'($urandom_range(0, 99));
      op = 6'($urandom);
      if (op == OP_HALT || op == OP_CALL || op == OP_RET) op = OP_ADD;
      if (r < 3) op = OP_HALT;
      else if (r < 11) op = OP_CALL;
      else if (r < 19) op = OP_RET;
      mem[a] = {op, 10'($urandom)};
    end
    for (int c = 0; c < 4000; c++) begin
      cyc();
      bus.start = ($urandom_range(0, 5) != 0);
      bus.stall = ($urandom_range(0, 9) == 0);
      bus.s_inc = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) async_reset(int'($urandom_range(2, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and sequencing stage of the single-cycle CPU, directly upstream of the control unit. Holds the program counter, addresses program memory, splits the returned word into the opcode for the control unit and the jump target, and computes the next PC from the control unit's `s_inc`. A run/halt state machine gates execution, and an optional hardware return stack adds CALL/RET.

## Interface
- `PC_WIDTH`, 10, program-counter width; jump target is `instr[PC_WIDTH-1:0]`.
- `INSTR_WIDTH`, 16, program-memory word width; opcode is `instr[INSTR_WIDTH-1:INSTR_WIDTH-6]`.
- `STACK_DEPTH`, 4, return-stack entries; power of two, 2..16. Used only with `FETCH_STACK_EN`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  level request to run the program.
- `stall`  in  1  freeze request; PC and state hold while high.
- `s_inc`  in  1  from control unit: 1 = PC+1, 0 = jump to target.
- `instr`  in  INSTR_WIDTH  program-memory data at address `pc`, combinational.
- `pc`  out  PC_WIDTH  program-memory address.
- `opcode`  out  6  `instr` top 6 bits, to control unit.
- `exec_en`  out  1  datapath write enable; the CPU ANDs `we3` and `wez` with it.
- `running`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.
- `stack_err`  out  1  sticky return-stack overflow/underflow flag.

## Operation
- States: IDLE, RUN, HALTED. Reset enters IDLE.
- IDLE: `pc` held at 0, `exec_en`=0. When `start`=1, go to RUN. `pc` stays 0, so the first instruction executes at address 0.
- RUN, `stall`=0:
  - opcode 6'b001111 (HALT): go to HALTED. `pc` holds and `exec_en`=0 that cycle.
  - Otherwise `exec_en`=1 and `pc` <= `s_inc` ? `pc`+1 : target.
  - `pc`+1 wraps from 2^PC_WIDTH−1 to 0 silently.
- RUN, `stall`=1: `pc`, state and stack hold, and `exec_en`=0.
- HALTED: `pc` holds. When `start`=0, go to IDLE and clear `pc` to 0. `stack_err` clears only on reset.
- `start` dropping during RUN has no effect. Only HALT or reset leaves RUN.
- `opcode` is always a combinational slice of `instr`, in every state.

## Timing
- Reset (asynchronous, active-low) sets: `pc`=0, state IDLE, `exec_en`=0, `running`=0, `halted`=0, `stack_err`=0, stack pointer 0.
- Reset asserted mid-RUN aborts immediately, with no clock needed.
- Single-cycle execution: one instruction per non-stalled RUN cycle.
  - `exec_en` is combinational from state, `stall` and `opcode`.
  - `pc` updates on the clock edge that ends the instruction.
- IDLE→RUN costs one cycle. The instruction at 0 executes in the first RUN cycle.
- `running` and `halted` are decoded from registered state.

## Configuration
- `FETCH_STACK_EN` defined: adds a STACK_DEPTH × PC_WIDTH return stack. Both operations below require RUN and `stall`=0.
  - CALL (6'b001100): push `pc`+1 and load target.
  - RET (6'b001101): pop into `pc`.
  - CALL on a full stack or RET on an empty stack: set `stack_err`, go to HALTED, leave stack and `pc` unchanged, `exec_en`=0.
- `FETCH_STACK_EN` undefined:
  - No stack storage.
  - CALL and RET follow `s_inc`, like any other non-HALT opcode; the control unit's default gives PC+1.
  - `stack_err` is tied to 0.

## Test plan
- Reset, then `start`=1 with program memory `ADD, ADD, HALT` at 0..2 → `pc` sequence 0,0(IDLE),1,2. `exec_en` high for two cycles, then `halted`=1 with `pc`=2.
- `s_inc`=0 at `pc`=5 with target 0x3F0 → next `pc`=0x3F0. Continuous `s_inc`=1 from 0x3FF → `pc` wraps to 0.
- `stall`=1 for 3 cycles at `pc`=7 → `pc` stays 7 and `exec_en`=0 throughout. The next unstalled cycle advances to 8.
- HALTED, `start` driven 1→0→1 → IDLE with `pc`=0, then RUN restarts at 0.
- With `FETCH_STACK_EN`, DEPTH=4: CALL from 0x010 to 0x100, then RET → `pc`=0x011. Five nested CALLs → fifth sets `stack_err`=1 and `halted`=1 with `pc` unchanged. RET with an empty stack after reset → `stack_err`=1.
- `reset` pulsed low mid-RUN at `pc`=0x123, asynchronous to `clk` → `pc`=0 and IDLE immediately. `stack_err` is cleared.
